// File: rtl/ula_pkg.sv
// Shared definitions for the ULA arbiter: OP byte layout, flag layout and FSM states.
package ula_pkg;

  typedef struct packed {
    logic [1:0] fmt;
    logic       r;
    logic [4:0] op;
  } ula_op_t;

  localparam logic [1:0] FMT_ARLO = 2'b10;

  typedef struct packed {
    logic o;
    logic c;
    logic s;
    logic z;
  } ula_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid at or above ptr (wrapping), plus the
// pointer value that follows the winner.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic [PW-1:0]   ptr_nxt
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(winner) == NREQ - 1) ? '0 : winner + PW'(1);

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin sharing of one combinational ULA between NREQ requesters.
// Define ULA_ARB_FLAGS_EN to keep the architectural O/C/S/Z flag register; otherwise flags read 0.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int BITS = 16,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_a,
  input  logic [NREQ*BITS-1:0] req_b,
  input  logic [NREQ*8-1:0]    req_op,
  output logic [NREQ-1:0]      resp_valid,
  output logic [BITS-1:0]      resp_data,
  output logic [BITS-1:0]      ula_a,
  output logic [BITS-1:0]      ula_b,
  output logic [7:0]           ula_op,
  input  logic [BITS-1:0]      ula_resu,
  input  logic [3:0]           ula_flags,
  output logic [3:0]           flags,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_nxt;
  logic [PW-1:0]   rr_ptr, owner, winner, ptr_nxt;
  logic [NREQ-1:0] grant;
  logic            xfer;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .valid   (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .winner  (winner),
    .ptr_nxt (ptr_nxt)
  );

  // Grants are offered in IDLE and again in RESP so ops can run back-to-back.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = 1'b0;
    case (state)
      IDLE:    req_ready = grant;
      EXEC:    busy = 1'b1;
      RESP: begin
        req_ready         = grant;
        resp_valid[owner] = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = xfer ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_op    <= '0;
      resp_data <= '0;
    end else begin
      if (xfer) begin
        ula_a  <= req_a[int'(winner)*BITS +: BITS];
        ula_b  <= req_b[int'(winner)*BITS +: BITS];
        ula_op <= req_op[int'(winner)*8 +: 8];
        owner  <= winner;
        rr_ptr <= ptr_nxt;
      end
      if (state == EXEC) resp_data <= ula_resu;
    end
  end

`ifdef ULA_ARB_FLAGS_EN
  ula_op_t op_q;
  assign op_q = ula_op_t'(ula_op);

  // Only arithmetic/logic ops touch the flags; constant formats leave them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      flags <= '0;
    else if (state == EXEC && op_q.fmt == FMT_ARLO) flags <= ula_flags;
  end
`else
  logic unused_flags;
  assign unused_flags = ^ula_flags;
  assign flags        = 4'b0000;
`endif

endmodule
